adbg_tap_ctrl: RTL and testbench



---
 rtl/adbg_tap_ctrl_if.sv | 27 ++
 rtl/adbg_tap_ctrl.sv | 137 +++++++++++++
 tb/tb_adbg_tap_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/adbg_tap_ctrl_if.sv
// JTAG pin and debug-top signal bundle for the TAP controller.
// slave: the TAP controller side; master: the pins/debug-top driver side.
interface adbg_tap_ctrl_if;
  logic tms_i;
  logic tdi_i;
  logic tdo_o;
  logic tdo_oe_o;
  logic debug_tdo_i;
  logic tlr_o;
  logic capture_dr_o;
  logic shift_dr_o;
  logic pause_dr_o;
  logic update_dr_o;
  logic debug_select_o;

  modport slave (
    input  tms_i, tdi_i, debug_tdo_i,
    output tdo_o, tdo_oe_o, tlr_o, capture_dr_o, shift_dr_o,
           pause_dr_o, update_dr_o, debug_select_o
  );

  modport master (
    output tms_i, tdi_i, debug_tdo_i,
    input  tdo_o, tdo_oe_o, tlr_o, capture_dr_o, shift_dr_o,
           pause_dr_o, update_dr_o, debug_select_o
  );
endinterface

// File: rtl/adbg_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, instruction register,
// IDCODE/BYPASS data registers, DR strobes and falling-edge TDO.
module adbg_tap_ctrl #(
  parameter int unsigned          IR_WIDTH     = 4,
  parameter logic [31:0]          IDCODE_VALUE = 32'h149511C3,
  parameter logic [IR_WIDTH-1:0]  OPC_IDCODE   = 4'b0010,
  parameter logic [IR_WIDTH-1:0]  OPC_DEBUG    = 4'b1000,
  parameter logic [IR_WIDTH-1:0]  OPC_BYPASS   = 4'b1111
) (
  input  logic           tck_i,
  input  logic           trstn_i,
  adbg_tap_ctrl_if.slave jtag
);

  localparam int unsigned DR_WIDTH = 32;

  localparam logic [3:0] TLR    = 4'h0;
  localparam logic [3:0] RTI    = 4'h1;
  localparam logic [3:0] SEL_DR = 4'h2;
  localparam logic [3:0] CAP_DR = 4'h3;
  localparam logic [3:0] SH_DR  = 4'h4;
  localparam logic [3:0] EX1_DR = 4'h5;
  localparam logic [3:0] PAU_DR = 4'h6;
  localparam logic [3:0] EX2_DR = 4'h7;
  localparam logic [3:0] UPD_DR = 4'h8;
  localparam logic [3:0] SEL_IR = 4'h9;
  localparam logic [3:0] CAP_IR = 4'hA;
  localparam logic [3:0] SH_IR  = 4'hB;
  localparam logic [3:0] EX1_IR = 4'hC;
  localparam logic [3:0] PAU_IR = 4'hD;
  localparam logic [3:0] EX2_IR = 4'hE;
  localparam logic [3:0] UPD_IR = 4'hF;

  logic [3:0]          state;
  logic [3:0]          state_next;
  logic [IR_WIDTH-1:0] ir;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [DR_WIDTH-1:0] idcode_sr;
  logic                bypass_sr;
  logic                tdo_q;
  logic                tdo_oe_q;
  logic                sel_idcode;
  logic                sel_debug;
  logic                sel_bypass;

  // OPC_BYPASS needs no decode of its own: anything unlisted already bypasses.
  assign sel_idcode = (ir == OPC_IDCODE);
  assign sel_debug  = (ir == OPC_DEBUG);
  assign sel_bypass = !sel_idcode && !sel_debug;

  // State register
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) state <= TLR;
    else          state <= state_next;
  end

  // Next-state decode on TMS
  always_comb begin
    state_next = state;
    case (state)
      TLR:    if (!jtag.tms_i) state_next = RTI;
      RTI:    if (jtag.tms_i)  state_next = SEL_DR;
      SEL_DR: state_next = jtag.tms_i ? SEL_IR : CAP_DR;
      CAP_DR: state_next = jtag.tms_i ? EX1_DR : SH_DR;
      SH_DR:  if (jtag.tms_i)  state_next = EX1_DR;
      EX1_DR: state_next = jtag.tms_i ? UPD_DR : PAU_DR;
      PAU_DR: if (jtag.tms_i)  state_next = EX2_DR;
      EX2_DR: state_next = jtag.tms_i ? UPD_DR : SH_DR;
      UPD_DR: state_next = jtag.tms_i ? SEL_DR : RTI;
      SEL_IR: state_next = jtag.tms_i ? TLR : CAP_IR;
      CAP_IR: state_next = jtag.tms_i ? EX1_IR : SH_IR;
      SH_IR:  if (jtag.tms_i)  state_next = EX1_IR;
      EX1_IR: state_next = jtag.tms_i ? UPD_IR : PAU_IR;
      PAU_IR: if (jtag.tms_i)  state_next = EX2_IR;
      EX2_IR: state_next = jtag.tms_i ? UPD_IR : SH_IR;
      UPD_IR: state_next = jtag.tms_i ? SEL_DR : RTI;
      default: state_next = TLR;
    endcase
  end

  // Instruction register; entering or holding TLR restores IDCODE immediately
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      ir    <= OPC_IDCODE;
      ir_sr <= '0;
    end else begin
      if (state == CAP_IR)     ir_sr <= IR_WIDTH'(2'b01);
      else if (state == SH_IR) ir_sr <= {jtag.tdi_i, ir_sr[IR_WIDTH-1:1]};

      if (state_next == TLR)   ir <= OPC_IDCODE;
      else if (state == UPD_IR) ir <= ir_sr;
    end
  end

  // IDCODE and BYPASS data registers
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      idcode_sr <= '0;
      bypass_sr <= 1'b0;
    end else begin
      if (state == CAP_DR && sel_idcode)     idcode_sr <= IDCODE_VALUE;
      else if (state == SH_DR && sel_idcode) idcode_sr <= {jtag.tdi_i, idcode_sr[DR_WIDTH-1:1]};

      if (state == CAP_DR && sel_bypass)     bypass_sr <= 1'b0;
      else if (state == SH_DR && sel_bypass) bypass_sr <= jtag.tdi_i;
    end
  end

  // TDO launched on the falling edge so it is stable at the next rising edge
  always_ff @(negedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_oe_q <= (state == SH_IR) || (state == SH_DR);
      case (state)
        SH_IR: tdo_q <= ir_sr[0];
        SH_DR: begin
          if (sel_idcode)     tdo_q <= idcode_sr[0];
          else if (sel_debug) tdo_q <= jtag.debug_tdo_i;
          else                tdo_q <= bypass_sr;
        end
        default: tdo_q <= tdo_q;
      endcase
    end
  end

  assign jtag.tdo_o          = tdo_q;
  assign jtag.tdo_oe_o       = tdo_oe_q;
  assign jtag.tlr_o          = (state == TLR);
  assign jtag.capture_dr_o   = (state == CAP_DR);
  assign jtag.shift_dr_o     = (state == SH_DR);
  assign jtag.pause_dr_o     = (state == PAU_DR);
  assign jtag.update_dr_o    = (state == UPD_DR);
  assign jtag.debug_select_o = sel_debug;

endmodule

// File: tb/tb_adbg_tap_ctrl.sv
// Directed bench for adbg_tap_ctrl: FSM walk table plus IR/DR scan sequences.
module tb_adbg_tap_ctrl;

  localparam logic [31:0] IDCODE = 32'h149511C3;

  logic tck;
  logic trstn;
  int   errors;
  int   checks;

  adbg_tap_ctrl_if jtag ();

  adbg_tap_ctrl dut (
    .tck_i   (tck),
    .trstn_i (trstn),
    .jtag    (jtag)
  );

  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       tms;
    logic [5:0] exp;   // {tlr, capture, shift, pause, update, tdo_oe}
  } vec_t;

  vec_t tbl [28];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One TCK cycle; returns with outputs settled just after the falling edge
  task automatic step(input logic tms, input logic tdi);
    jtag.tms_i = tms;
    jtag.tdi_i = tdi;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  function automatic logic [5:0] strobes();
    return {jtag.tlr_o, jtag.capture_dr_o, jtag.shift_dr_o,
            jtag.pause_dr_o, jtag.update_dr_o, jtag.tdo_oe_o};
  endfunction

  // Full IR or DR scan of n bits from RTI back to RTI, LSB first
  task automatic scan(input logic ir_scan, input int n, input logic [31:0] din,
                      output logic [31:0] dout);
    dout = '0;
    step(1'b1, 1'b0);
    if (ir_scan) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    dout[0] = jtag.tdo_o;
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i]);
      if (i < n - 1) dout[i+1] = jtag.tdo_o;
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] got;
    logic [4:0]  dpat;

    errors = 0;
    checks = 0;

    tbl[0]  = '{1'b0, 6'b000000};  // RTI
    tbl[1]  = '{1'b1, 6'b000000};  // SelDR
    tbl[2]  = '{1'b0, 6'b010000};  // CapDR
    tbl[3]  = '{1'b0, 6'b001001};  // ShDR
    tbl[4]  = '{1'b0, 6'b001001};  // ShDR
    tbl[5]  = '{1'b1, 6'b000000};  // Ex1DR
    tbl[6]  = '{1'b0, 6'b000100};  // PauDR
    tbl[7]  = '{1'b0, 6'b000100};  // PauDR
    tbl[8]  = '{1'b1, 6'b000000};  // Ex2DR
    tbl[9]  = '{1'b0, 6'b001001};  // ShDR
    tbl[10] = '{1'b1, 6'b000000};  // Ex1DR
    tbl[11] = '{1'b1, 6'b000010};  // UpdDR
    tbl[12] = '{1'b1, 6'b000000};  // SelDR
    tbl[13] = '{1'b1, 6'b000000};  // SelIR
    tbl[14] = '{1'b0, 6'b000000};  // CapIR
    tbl[15] = '{1'b0, 6'b000001};  // ShIR
    tbl[16] = '{1'b1, 6'b000000};  // Ex1IR
    tbl[17] = '{1'b0, 6'b000000};  // PauIR
    tbl[18] = '{1'b1, 6'b000000};  // Ex2IR
    tbl[19] = '{1'b0, 6'b000001};  // ShIR
    tbl[20] = '{1'b1, 6'b000000};  // Ex1IR
    tbl[21] = '{1'b1, 6'b000000};  // UpdIR
    tbl[22] = '{1'b0, 6'b000000};  // RTI
    tbl[23] = '{1'b0, 6'b000000};  // RTI
    tbl[24] = '{1'b1, 6'b000000};  // SelDR
    tbl[25] = '{1'b1, 6'b000000};  // SelIR
    tbl[26] = '{1'b1, 6'b100000};  // TLR
    tbl[27] = '{1'b1, 6'b100000};  // TLR

    trstn            = 1'b0;
    jtag.tms_i       = 1'b1;
    jtag.tdi_i       = 1'b0;
    jtag.debug_tdo_i = 1'b0;
    #12;
    check("reset_outputs", 32'({strobes(), jtag.debug_select_o, jtag.tdo_o}), 32'b10000000);
    @(negedge tck);
    #1 trstn = 1'b1;

    for (int i = 0; i < 28; i++) begin
      step(tbl[i].tms, 1'b0);
      check($sformatf("walk[%0d]", i), 32'(strobes()), 32'(tbl[i].exp));
    end
    step(1'b0, 1'b0);  // RTI

    // DEBUG load, then reset in the middle of a DR shift
    scan(1'b1, 4, 32'h8, got);
    check("debug_sel_before_rst", 32'(jtag.debug_select_o), 32'd1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    #2 trstn = 1'b0;
    #1;
    check("rst_mid_shift", 32'({jtag.tlr_o, jtag.shift_dr_o, jtag.tdo_oe_o, jtag.debug_select_o}),
          32'b1000);
    @(negedge tck);
    #1 trstn = 1'b1;
    step(1'b0, 1'b0);
    scan(1'b0, 32, 32'h0, got);
    check("idcode_after_rst", got, IDCODE);

    // Five TMS=1 from RTI must undo a DEBUG load
    scan(1'b1, 4, 32'h8, got);
    check("debug_sel_loaded", 32'(jtag.debug_select_o), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("tms5_tlr", 32'(jtag.tlr_o), 32'd1);
    step(1'b1, 1'b0);
    check("tms5_debug_sel", 32'({jtag.tlr_o, jtag.debug_select_o}), 32'b10);
    step(1'b0, 1'b0);
    scan(1'b0, 8, 32'h0, got);
    check("tms5_idcode_byte", got, 32'hC3);

    // IR capture pattern, then BYPASS one-bit delay
    scan(1'b1, 4, 32'hF, got);
    check("ir_capture", got, 32'h1);
    check("bypass_no_dsel", 32'(jtag.debug_select_o), 32'd0);
    scan(1'b0, 4, 32'b1101, got);
    check("bypass_delay", got, 32'b1010);

    // DEBUG path: TDO mirrors debug_tdo_i, strobes framed per state
    scan(1'b1, 4, 32'h8, got);
    check("debug_sel", 32'(jtag.debug_select_o), 32'd1);
    dpat = 5'b01101;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("dbg_capdr", 32'(strobes()), 32'b010000);
    jtag.debug_tdo_i = dpat[0];
    step(1'b0, 1'b0);
    check("dbg_shdr_strobe", 32'(strobes()), 32'b001001);
    check("dbg_tdo[0]", 32'(jtag.tdo_o), 32'(dpat[0]));
    for (int i = 1; i < 5; i++) begin
      jtag.debug_tdo_i = dpat[i];
      step(1'b0, 1'b0);
      check($sformatf("dbg_tdo[%0d]", i), 32'(jtag.tdo_o), 32'(dpat[i]));
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("dbg_pause", 32'(strobes()), 32'b000100);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("dbg_ex2", 32'(strobes()), 32'b000000);
    step(1'b1, 1'b0);
    check("dbg_update", 32'(strobes()), 32'b000010);
    step(1'b0, 1'b0);
    check("dbg_rti", 32'(strobes()), 32'b000000);

    // Unlisted opcode behaves as bypass
    scan(1'b1, 4, 32'b0101, got);
    check("opc0101_dsel", 32'(jtag.debug_select_o), 32'd0);
    scan(1'b0, 4, 32'b0011, got);
    check("opc0101_bypass", got, 32'b0110);

    // IDCODE shift interrupted by a 3-cycle pause
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    got = '0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    got[0] = jtag.tdo_o;
    for (int i = 0; i < 32; i++) begin
      if (i == 15) begin
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("pause_hold_oe", 32'(strobes()), 32'b000100);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        got[16] = jtag.tdo_o;
      end else begin
        step(i == 31, 1'b0);
        if (i < 31) got[i+1] = jtag.tdo_o;
      end
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("idcode_across_pause", got, IDCODE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
